// File: rtl/int4_interp_pkg.sv
// rtl/int4_interp_pkg.sv - shared constants, state enum and interpolation helper
package int4_interp_pkg;

  localparam int SAMP_W = 16;
  localparam int N_IN   = 4;
  localparam int N_OUT  = 16;
  localparam int ACC_W  = 19;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  // ((4-k)*prev + k*cur) >>> 2 in ACC_W bits; built from shifts and adds
  function automatic logic [SAMP_W-1:0] interp_pt(input logic [SAMP_W-1:0] prev,
                                                  input logic [SAMP_W-1:0] cur,
                                                  input logic [1:0]        k);
    logic signed [ACC_W-1:0] p;
    logic signed [ACC_W-1:0] c;
    logic signed [ACC_W-1:0] acc;
    p = {{(ACC_W-SAMP_W){prev[SAMP_W-1]}}, prev};
    c = {{(ACC_W-SAMP_W){cur[SAMP_W-1]}}, cur};
    case (k)
      2'd0:    acc = p <<< 2;
      2'd1:    acc = (p <<< 1) + p + c;
      2'd2:    acc = (p + c) <<< 1;
      default: acc = p + (c <<< 1) + c;
    endcase
    acc = acc >>> 2;
    return acc[SAMP_W-1:0];
  endfunction

endpackage

// File: rtl/int4_interp_fifo.sv
// rtl/int4_interp_fifo.sv - synchronous beat FIFO with extra pointer bit for full/empty
module int4_interp_fifo #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [127:0]  din,
  input  logic          pop,
  output logic [127:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [127:0] mem [FIFO_DEPTH];
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axis_int4_interp.sv
// rtl/axis_int4_interp.sv - interpolate-by-4 front end: FIFO, prime/run control, 2-stage interpolator
module axis_int4_interp
  import int4_interp_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PRIME_LVL  = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [511:0] dout,
  output logic         dout_valid,
  input  logic         EN_REG,
  input  logic         UFLOW_CLR_REG,
  output logic         UFLOW_REG
);

  localparam int AW = $clog2(FIFO_DEPTH);

  state_t       state;
  state_t       state_nxt;
  logic         ready_en;
  logic         push;
  logic         pop_try;
  logic         pop_ok;
  logic         uflow_ev;
  logic         leave_run;
  logic [127:0] fifo_dout;
  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic [31:0]  hist;
  logic         s1_valid;
  logic [127:0] s1_beat;
  logic [31:0]  s1_hist;
  logic [511:0] interp;

  // ready_en keeps tready low while reset is asserted
  assign s_axis_tready = ready_en && !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;

  int4_interp_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (s_axis_tdata),
    .pop   (pop_ok),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_try   = 1'b0;
    case (state)
      IDLE:  if (EN_REG) state_nxt = PRIME;
      PRIME: begin
        if (!EN_REG) state_nxt = IDLE;
        else if (fifo_count >= (AW+1)'(PRIME_LVL)) state_nxt = RUN;
      end
      RUN: begin
        pop_try = 1'b1;
        if (!EN_REG) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop_ok    = pop_try && !fifo_empty;
  assign uflow_ev  = pop_try && fifo_empty;
  assign leave_run = (state != IDLE) && (state_nxt == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_en   <= 1'b0;
      hist       <= '0;
      s1_valid   <= 1'b0;
      s1_beat    <= '0;
      s1_hist    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      UFLOW_REG  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (pop_ok) hist <= fifo_dout[127:96];
      if (uflow_ev || leave_run) hist <= '0;
      s1_valid <= pop_ok;
      if (pop_ok) begin
        s1_beat <= fifo_dout;
        s1_hist <= hist;
      end
      dout_valid <= s1_valid;
      dout       <= s1_valid ? interp : '0;
      if (uflow_ev)           UFLOW_REG <= 1'b1;
      else if (UFLOW_CLR_REG) UFLOW_REG <= 1'b0;
    end
  end

  // slot 4j+k blends x[j-1] and x[j]; x[-1] is the previous beat's last sample
  for (genvar s = 0; s < N_OUT; s++) begin : g_slot
    for (genvar c = 0; c < 2; c++) begin : g_comp
      localparam int J = s / N_IN;
      localparam int K = s % N_IN;
      logic [SAMP_W-1:0] prev_s;
      logic [SAMP_W-1:0] cur_s;
      if (J == 0) begin : g_hist
        assign prev_s = s1_hist[16*c +: 16];
      end else begin : g_beat
        assign prev_s = s1_beat[32*(J-1)+16*c +: 16];
      end
      assign cur_s = s1_beat[32*J+16*c +: 16];
      assign interp[32*s+16*c +: 16] = interp_pt(prev_s, cur_s, 2'(K));
    end
  end

endmodule

// File: tb/tb_axis_int4_interp.sv
// tb/tb_axis_int4_interp.sv - self-checking bench for axis_int4_interp
module tb_axis_int4_interp;

  logic         clk = 1'b0;
  logic         rstn;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] dout;
  logic         dout_valid;
  logic         EN_REG;
  logic         UFLOW_CLR_REG;
  logic         UFLOW_REG;

  always #5 clk = ~clk;

  axis_int4_interp #(.FIFO_DEPTH(8), .PRIME_LVL(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .EN_REG        (EN_REG),
    .UFLOW_CLR_REG (UFLOW_CLR_REG),
    .UFLOW_REG     (UFLOW_REG)
  );

  typedef struct {
    logic [63:0] i;
    logic [63:0] q;
    logic [63:0] e_lo;
    logic [63:0] e_hi;
  } vec_t;

  vec_t         tbl [5];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [511:0] exp_q [$];
  logic [511:0] seen [$];
  int           seen_cyc [$];
  logic [31:0]  hist_m;

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [127:0] mk(input logic [63:0] i, input logic [63:0] q);
    logic [127:0] r;
    for (int m = 0; m < 4; m++) begin
      r[32*m +: 16]    = i[16*m +: 16];
      r[32*m+16 +: 16] = q[16*m +: 16];
    end
    return r;
  endfunction

  function automatic logic [63:0] slots_i(input logic [511:0] d, input int base);
    logic [63:0] r;
    for (int s = 0; s < 4; s++) r[16*s +: 16] = d[32*(base+s) +: 16];
    return r;
  endfunction

  function automatic logic [511:0] model(input logic [127:0] b, input logic [31:0] h);
    logic [511:0] r;
    int p, x, v, j, k;
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 2; c++) begin
        j = s / 4;
        k = s % 4;
        if (j == 0) p = $signed(h[16*c +: 16]);
        else        p = $signed(b[32*(j-1)+16*c +: 16]);
        x = $signed(b[32*j+16*c +: 16]);
        v = ((4-k)*p + k*x) >>> 2;
        r[32*s+16*c +: 16] = v[15:0];
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (dout_valid) begin
          seen.push_back(dout);
          seen_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_dout: got %0h required no output", dout);
          end else begin
            chk("dout", dout, exp_q.pop_front());
          end
        end else begin
          chk("dout_gated", dout, '0);
        end
      end
    end
  endtask

  task automatic push(input logic [127:0] d);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (s_axis_tready) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back(model(d, hist_m));
      hist_m = d[127:96];
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    chk("push_accept", 512'(ok), 512'(1));
  endtask

  task automatic wait_seen(input int n);
    for (int c = 0; c < 200 && seen.size() < n; c++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_seen", 512'(seen.size() >= n), 512'(1));
  endtask

  initial begin
    int base;
    logic [127:0] d9;
    tbl[0] = '{pk(400, 800, 1200, 1600), pk(0, 0, 0, 0),
               pk(0, 100, 200, 300), pk(1200, 1300, 1400, 1500)};
    tbl[1] = '{pk(0, 0, 0, 0), pk(100, -100, 7, -7),
               pk(1600, 1200, 800, 400), pk(0, 0, 0, 0)};
    tbl[2] = '{pk(-1, 0, 0, 0), pk(-32768, 32767, -32768, 32767),
               pk(0, -1, -1, -1), pk(0, 0, 0, 0)};
    tbl[3] = '{pk(0, 0, 0, 32767), pk(1, 2, 3, 4),
               pk(0, 0, 0, 0), pk(0, 8191, 16383, 24575)};
    tbl[4] = '{pk(-32768, -32768, -32768, -32768), pk(-5, 5, -5, 5),
               pk(32767, 16383, -1, -16385), pk(-32768, -32768, -32768, -32768)};

    rstn = 1'b0; EN_REG = 1'b0; UFLOW_CLR_REG = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; hist_m = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 512'(s_axis_tready), 512'(0));
    chk("rst_dout", dout, '0);
    chk("rst_valid", 512'(dout_valid), 512'(0));
    chk("rst_uflow", 512'(UFLOW_REG), 512'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_tready", 512'(s_axis_tready), 512'(1));

    // table vectors streamed back to back
    EN_REG = 1'b1;
    for (int v = 0; v < 5; v++) push(mk(tbl[v].i, tbl[v].q));
    wait_seen(5);
    for (int v = 0; v < 5 && v < seen.size(); v++) begin
      chk($sformatf("tbl%0d_lo", v), 512'(slots_i(seen[v], 0)), 512'(tbl[v].e_lo));
      chk($sformatf("tbl%0d_hi", v), 512'(slots_i(seen[v], 12)), 512'(tbl[v].e_hi));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("uflow_set", 512'(UFLOW_REG), 512'(1));

    // after underflow, history restarts from zero
    hist_m = '0;
    push(mk(pk(400, 800, 1200, 1600), pk(0, 0, 0, 0)));
    wait_seen(6);
    if (seen.size() >= 6)
      chk("uflow_resume", 512'(slots_i(seen[5], 0)), 512'(pk(0, 100, 200, 300)));

    // set beats clear while underflowing
    UFLOW_CLR_REG = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("uflow_set_prio", 512'(UFLOW_REG), 512'(1));
    EN_REG = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("uflow_clr", 512'(UFLOW_REG), 512'(0));
    UFLOW_CLR_REG = 1'b0;

    // flag rises together with the last buffered beat's output
    hist_m = '0;
    for (int b = 0; b < 4; b++) push({$urandom, $urandom, $urandom, $urandom});
    base = seen.size();
    EN_REG = 1'b1;
    wait_seen(base + 3);
    chk("uflow_before", 512'(UFLOW_REG), 512'(0));
    @(negedge clk);
    #1;
    chk("last_beat_seen", 512'(seen.size()), 512'(base + 4));
    chk("uflow_timing", 512'(UFLOW_REG), 512'(1));
    EN_REG = 1'b0;
    UFLOW_CLR_REG = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    UFLOW_CLR_REG = 1'b0;

    // backpressure: 8 accepted, 9th held until streaming starts
    hist_m = '0;
    for (int b = 0; b < 8; b++) push({$urandom, $urandom, $urandom, $urandom});
    d9 = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tdata  = d9;
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_tready", 512'(s_axis_tready), 512'(0));
    exp_q.push_back(model(d9, hist_m));
    hist_m = d9[127:96];
    base = seen.size();
    EN_REG = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
        @(negedge clk);
        if (s_axis_tready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      chk("ninth_accept", 512'(ok), 512'(1));
    end
    wait_seen(base + 9);
    if (seen_cyc.size() >= base + 9)
      chk("back_to_back", 512'(seen_cyc[base+8] - seen_cyc[base]), 512'(8));

    // reset in the middle of a run
    EN_REG = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hist_m = '0;
    for (int b = 0; b < 6; b++) push({$urandom, $urandom, $urandom, $urandom});
    base = seen.size();
    EN_REG = 1'b1;
    wait_seen(base + 2);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_dout", dout, '0);
    chk("mid_rst_valid", 512'(dout_valid), 512'(0));
    chk("mid_rst_tready", 512'(s_axis_tready), 512'(0));
    exp_q.delete();
    EN_REG = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tready_rel", 512'(s_axis_tready), 512'(1));
    base = seen.size();
    EN_REG = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("fifo_flushed", 512'(seen.size()), 512'(base));
    chk("no_uflow_prime", 512'(UFLOW_REG), 512'(0));
    hist_m = '0;
    for (int b = 0; b < 4; b++) push({$urandom, $urandom, $urandom, $urandom});
    wait_seen(base + 4);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
